lsu_mem_master: RTL and testbench

//  Load/store initiator between the core's execute stage and the byte-addressed data memory.
//  - Accepts one load/store per handshake.
//  - Aligned accesses use a single native MEM_Ctrl access.
//  - Misaligned accesses are split into sequential byte accesses, and the load result is reassembled.
//  - Returns the result with a one-cycle rsp_valid pulse. The core stalls while req_ready is low.

---
 rtl/lsu_mem_master.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_master.sv
// rtl/lsu_mem_master.sv - load/store initiator with misaligned access splitting
// Purpose: accepts one load/store per handshake from the execute stage, issues a
//   native memory access for aligned requests, or a sequence of byte accesses
//   for misaligned ones (reassembling and extending load data), then returns
//   the result with a one-cycle rsp_valid pulse.
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   req_valid/req_ready           request handshake (ready only while idle)
//   req_we/req_funct3/req_addr/req_wdata   request fields (RV32I load/store encoding)
//   rsp_valid/rsp_rdata/rsp_err   response pulse, load data, error flag
//   MEMR/MEMW/MEM_Ctrl            memory strobes and access type
//   mem_addr/mem_wdata/mem_rdata  memory address, write data, combinational read data
module lsu_mem_master #(
  parameter int MEM_BYTES        = 4096,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        MEMR,
  output logic        MEMW,
  output logic [3:0]  MEM_Ctrl,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_SPLIT, S_RESP} state_t;

  state_t      r_state;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_cnt;
  logic [1:0]  r_last;
  logic [31:0] r_asm;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_rdata;
  logic        r_rsp_err;
  logic        r_memr;
  logic        r_memw;
  logic [3:0]  r_mem_ctrl;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;

  logic [2:0]  w_size;
  logic [1:0]  w_last;
  logic        w_illegal;
  logic [32:0] w_end;
  logic        w_oor;
  logic        w_misaligned;
  logic [3:0]  w_native;
  logic [1:0]  w_cnt_nx;
  logic [31:0] w_asm_nx;

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign MEMR      = r_memr;
  assign MEMW      = r_memw;
  assign MEM_Ctrl  = r_mem_ctrl;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Access size from funct3; illegal encodings get a size too but are rejected anyway.
  always_comb begin
    w_size = 3'd1;
    w_last = 2'd0;
    case (req_funct3[1:0])
      2'd1: begin w_size = 3'd2; w_last = 2'd1; end
      2'd2: begin w_size = 3'd4; w_last = 2'd3; end
      default: ;
    endcase
  end

  assign w_illegal    = req_we ? (req_funct3 >= 3'd3)
                               : (req_funct3 == 3'd3 || req_funct3[2:1] == 2'b11);
  // 33-bit end address so a request near 0xffffffff cannot wrap into range.
  assign w_end        = {1'b0, req_addr} + {30'd0, w_size} - 33'd1;
  assign w_oor        = w_end >= 33'(MEM_BYTES);
  assign w_misaligned = (w_size == 3'd2 && req_addr[0]) ||
                        (w_size == 3'd4 && req_addr[1:0] != 2'b00);

  always_comb begin
    w_native = 4'd0;
    case ({req_we, req_funct3})
      4'b0_000: w_native = 4'd0;
      4'b0_001: w_native = 4'd1;
      4'b0_010: w_native = 4'd2;
      4'b0_100: w_native = 4'd3;
      4'b0_101: w_native = 4'd4;
      4'b1_000: w_native = 4'd5;
      4'b1_001: w_native = 4'd6;
      4'b1_010: w_native = 4'd7;
      default:  w_native = 4'd0;
    endcase
  end

  assign w_cnt_nx = r_cnt + 2'd1;

  // Assembly with the byte returned this cycle merged into lane r_cnt.
  always_comb begin
    w_asm_nx = r_asm;
    w_asm_nx[{r_cnt, 3'b000} +: 8] = mem_rdata[7:0];
  end

  function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] v);
    case (f3)
      3'd0:    return {{24{v[7]}}, v[7:0]};
      3'd1:    return {{16{v[15]}}, v[15:0]};
      3'd4:    return {24'd0, v[7:0]};
      3'd5:    return {16'd0, v[15:0]};
      default: return v;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_we        <= 1'b0;
      r_funct3    <= 3'd0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_cnt       <= 2'd0;
      r_last      <= 2'd0;
      r_asm       <= 32'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
      r_memr      <= 1'b0;
      r_memw      <= 1'b0;
      r_mem_ctrl  <= 4'd0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid && r_req_ready) begin
            r_we        <= req_we;
            r_funct3    <= req_funct3;
            r_addr      <= req_addr;
            r_wdata     <= req_wdata;
            r_last      <= w_last;
            r_cnt       <= 2'd0;
            r_asm       <= 32'd0;
            r_req_ready <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
            if (w_illegal || w_oor || (w_misaligned && !ALLOW_MISALIGNED)) begin
              r_rsp_err   <= 1'b1;
              r_rsp_valid <= 1'b1;
              r_state     <= S_RESP;
            end else if (w_misaligned) begin
              // First byte of the split sequence is issued straight from the request.
              r_memr      <= !req_we;
              r_memw      <= req_we;
              r_mem_ctrl  <= req_we ? 4'd5 : 4'd3;
              r_mem_addr  <= req_addr;
              r_mem_wdata <= {24'd0, req_wdata[7:0]};
              r_state     <= S_SPLIT;
            end else begin
              r_memr      <= !req_we;
              r_memw      <= req_we;
              r_mem_ctrl  <= w_native;
              r_mem_addr  <= req_addr;
              r_mem_wdata <= req_wdata;
              r_state     <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          r_memr      <= 1'b0;
          r_memw      <= 1'b0;
          if (!r_we) r_rsp_rdata <= mem_rdata;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_SPLIT: begin
          if (!r_we) r_asm <= w_asm_nx;
          if (r_cnt == r_last) begin
            r_memr      <= 1'b0;
            r_memw      <= 1'b0;
            if (!r_we) r_rsp_rdata <= extend(r_funct3, w_asm_nx);
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_cnt       <= w_cnt_nx;
            r_mem_addr  <= r_addr + {30'd0, w_cnt_nx};
            r_mem_wdata <= {24'd0, r_wdata[{w_cnt_nx, 3'b000} +: 8]};
          end
        end
        S_RESP: begin
          r_rsp_valid <= 1'b0;
          r_req_ready <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb/tb_lsu_mem_master.sv - directed vector bench for lsu_mem_master
`timescale 1ns/1ps
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        reqv_a, reqv_b;
  logic        req_we;
  logic [2:0]  req_f3;
  logic [31:0] req_addr, req_wdata;

  logic        rdy_a, rv_a, er_a, memr_a, memw_a;
  logic [31:0] rd_a, maddr_a, mwd_a, mrd_a;
  logic [3:0]  ctrl_a;
  logic        rdy_b, rv_b, er_b, memr_b, memw_b;
  logic [31:0] rd_b, maddr_b, mwd_b, mrd_b;
  logic [3:0]  ctrl_b;

  logic [7:0]  mem_a [0:4095];
  logic [7:0]  mem_b [0:4095];

  int n_cmp = 0;
  int n_bad = 0;
  int both_hi = 0;

  logic [31:0] log_addr[$];
  logic [3:0]  log_ctrl[$];
  logic [31:0] log_wd[$];

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_BYTES(4096), .ALLOW_MISALIGNED(1'b1)) u_a (
    .clk(clk), .rst(rst), .req_valid(reqv_a), .req_ready(rdy_a), .req_we(req_we),
    .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_a), .rsp_rdata(rd_a), .rsp_err(er_a), .MEMR(memr_a), .MEMW(memw_a),
    .MEM_Ctrl(ctrl_a), .mem_addr(maddr_a), .mem_wdata(mwd_a), .mem_rdata(mrd_a));

  lsu_mem_master #(.MEM_BYTES(4096), .ALLOW_MISALIGNED(1'b0)) u_b (
    .clk(clk), .rst(rst), .req_valid(reqv_b), .req_ready(rdy_b), .req_we(req_we),
    .req_funct3(req_f3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rv_b), .rsp_rdata(rd_b), .rsp_err(er_b), .MEMR(memr_b), .MEMW(memw_b),
    .MEM_Ctrl(ctrl_b), .mem_addr(maddr_b), .mem_wdata(mwd_b), .mem_rdata(mrd_b));

  function automatic logic [7:0] mb(input bit b, input logic [31:0] a);
    if (a >= 32'd4096) return 8'h00;
    return b ? mem_b[a[11:0]] : mem_a[a[11:0]];
  endfunction

  // Memory model: MEM_Ctrl selects width and extension of the combinational read.
  function automatic logic [31:0] mread(input bit b, input logic [3:0] c, input logic [31:0] a);
    logic [7:0] b0, b1, b2, b3;
    b0 = mb(b, a); b1 = mb(b, a + 32'd1); b2 = mb(b, a + 32'd2); b3 = mb(b, a + 32'd3);
    case (c)
      4'd0:    return {{24{b0[7]}}, b0};
      4'd1:    return {{16{b1[7]}}, b1, b0};
      4'd2:    return {b3, b2, b1, b0};
      4'd3:    return {24'd0, b0};
      4'd4:    return {16'd0, b1, b0};
      default: return 32'd0;
    endcase
  endfunction

  function automatic int nbytes(input logic [3:0] c);
    case (c)
      4'd5: return 1;
      4'd6: return 2;
      4'd7: return 4;
      default: return 0;
    endcase
  endfunction

  assign mrd_a = memr_a ? mread(1'b0, ctrl_a, maddr_a) : 32'd0;
  assign mrd_b = memr_b ? mread(1'b1, ctrl_b, maddr_b) : 32'd0;

  always @(posedge clk) begin
    if (memw_a)
      for (int j = 0; j < 4; j++)
        if (j < nbytes(ctrl_a) && maddr_a + 32'(j) < 32'd4096)
          mem_a[12'(maddr_a + 32'(j))] <= mwd_a[8*j +: 8];
    if (memw_b)
      for (int j = 0; j < 4; j++)
        if (j < nbytes(ctrl_b) && maddr_b + 32'(j) < 32'd4096)
          mem_b[12'(maddr_b + 32'(j))] <= mwd_b[8*j +: 8];
  end

  always @(negedge clk) begin
    if ((memr_a && memw_a) || (memr_b && memw_b)) both_hi++;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the idle cycle after the response.
  task automatic do_req(input bit b, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rdata, output logic err,
                        output int lat, output int nr, output int nw, output int busy_bad);
    req_we = we; req_f3 = f3; req_addr = a; req_wdata = wd;
    if (b) reqv_b = 1'b1; else reqv_a = 1'b1;
    chk("ready_at_request", {31'd0, b ? rdy_b : rdy_a}, 32'd1);
    @(posedge clk); #1;
    reqv_a = 1'b0; reqv_b = 1'b0;
    lat = -1; nr = 0; nw = 0; busy_bad = 0; rdata = 32'hx; err = 1'bx;
    log_addr.delete(); log_ctrl.delete(); log_wd.delete();
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (b ? rdy_b : rdy_a) busy_bad++;
      if (b ? memr_b : memr_a) nr++;
      if (b ? memw_b : memw_a) nw++;
      if ((b ? memr_b : memr_a) || (b ? memw_b : memw_a)) begin
        log_addr.push_back(b ? maddr_b : maddr_a);
        log_ctrl.push_back(b ? ctrl_b : ctrl_a);
        log_wd.push_back(b ? mwd_b : mwd_a);
      end
      if (b ? rv_b : rv_a) begin
        lat = k + 1; rdata = b ? rd_b : rd_a; err = b ? er_b : er_a;
        break;
      end
    end
    @(negedge clk);
    chk("rsp_valid_one_cycle", {31'd0, b ? rv_b : rv_a}, 32'd0);
    chk("ready_after_resp", {31'd0, b ? rdy_b : rdy_a}, 32'd1);
    chk("rdata_hold", b ? rd_b : rd_a, rdata);
  endtask

  typedef struct {
    bit          b;
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_nr;
    int          exp_nw;
  } vec_t;

  vec_t vecs[34];

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          lat, nr, nw, busy_bad;

    vecs[0]  = '{0, 0, 3'd2, 32'd0,          32'd0,          32'haabbccdd, 0, 2, 1, 0};
    vecs[1]  = '{0, 0, 3'd0, 32'd0,          32'd0,          32'hffffffdd, 0, 2, 1, 0};
    vecs[2]  = '{0, 0, 3'd4, 32'd0,          32'd0,          32'h000000dd, 0, 2, 1, 0};
    vecs[3]  = '{0, 0, 3'd5, 32'd6,          32'd0,          32'h00001122, 0, 2, 1, 0};
    vecs[4]  = '{0, 0, 3'd1, 32'd2,          32'd0,          32'hffffaabb, 0, 2, 1, 0};
    vecs[5]  = '{0, 0, 3'd2, 32'd1,          32'd0,          32'h44aabbcc, 0, 5, 4, 0};
    vecs[6]  = '{0, 1, 3'd1, 32'd3,          32'h00001234,   32'h0,        0, 3, 0, 2};
    vecs[7]  = '{0, 0, 3'd2, 32'd4,          32'd0,          32'h11223312, 0, 2, 1, 0};
    vecs[8]  = '{0, 0, 3'd1, 32'd3,          32'd0,          32'h00001234, 0, 3, 2, 0};
    vecs[9]  = '{0, 0, 3'd1, 32'd1,          32'd0,          32'hffffbbcc, 0, 3, 2, 0};
    vecs[10] = '{0, 0, 3'd5, 32'd1,          32'd0,          32'h0000bbcc, 0, 3, 2, 0};
    vecs[11] = '{0, 0, 3'd3, 32'd0,          32'd0,          32'h0,        1, 1, 0, 0};
    vecs[12] = '{0, 1, 3'd4, 32'd0,          32'h55,         32'h0,        1, 1, 0, 0};
    vecs[13] = '{0, 0, 3'd7, 32'd0,          32'd0,          32'h0,        1, 1, 0, 0};
    vecs[14] = '{0, 0, 3'd2, 32'd4094,       32'd0,          32'h0,        1, 1, 0, 0};
    vecs[15] = '{0, 0, 3'd2, 32'd4092,       32'd0,          32'h0,        0, 2, 1, 0};
    vecs[16] = '{0, 0, 3'd0, 32'd4095,       32'd0,          32'h0,        0, 2, 1, 0};
    vecs[17] = '{0, 0, 3'd1, 32'd4095,       32'd0,          32'h0,        1, 1, 0, 0};
    vecs[18] = '{0, 0, 3'd0, 32'hffffffff,   32'd0,          32'h0,        1, 1, 0, 0};
    vecs[19] = '{0, 1, 3'd2, 32'd8,          32'h80a1b2c3,   32'h0,        0, 2, 0, 1};
    vecs[20] = '{0, 0, 3'd0, 32'd11,         32'd0,          32'hffffff80, 0, 2, 1, 0};
    vecs[21] = '{0, 1, 3'd0, 32'd9,          32'hffffff55,   32'h0,        0, 2, 0, 1};
    vecs[22] = '{0, 0, 3'd2, 32'd8,          32'd0,          32'h80a155c3, 0, 2, 1, 0};
    vecs[23] = '{0, 1, 3'd2, 32'd13,         32'hdeadbeef,   32'h0,        0, 5, 0, 4};
    vecs[24] = '{0, 0, 3'd2, 32'd13,         32'd0,          32'hdeadbeef, 0, 5, 4, 0};
    vecs[25] = '{0, 0, 3'd4, 32'd16,         32'd0,          32'h000000de, 0, 2, 1, 0};
    vecs[26] = '{0, 0, 3'd5, 32'd15,         32'd0,          32'h0000dead, 0, 3, 2, 0};
    vecs[27] = '{0, 1, 3'd2, 32'd4093,       32'h1,          32'h0,        1, 1, 0, 0};
    vecs[28] = '{1, 0, 3'd1, 32'd1,          32'd0,          32'h0,        1, 1, 0, 0};
    vecs[29] = '{1, 0, 3'd2, 32'd4094,       32'd0,          32'h0,        1, 1, 0, 0};
    vecs[30] = '{1, 0, 3'd2, 32'd0,          32'd0,          32'haabbccdd, 0, 2, 1, 0};
    vecs[31] = '{1, 1, 3'd2, 32'd2,          32'h12345678,   32'h0,        1, 1, 0, 0};
    vecs[32] = '{1, 0, 3'd0, 32'd1,          32'd0,          32'hffffffcc, 0, 2, 1, 0};
    vecs[33] = '{1, 0, 3'd5, 32'd6,          32'd0,          32'h00001122, 0, 2, 1, 0};

    for (int i = 0; i < 4096; i++) begin mem_a[i] = 8'h00; mem_b[i] = 8'h00; end
    mem_a[0] = 8'hdd; mem_a[1] = 8'hcc; mem_a[2] = 8'hbb; mem_a[3] = 8'haa;
    mem_a[4] = 8'h44; mem_a[5] = 8'h33; mem_a[6] = 8'h22; mem_a[7] = 8'h11;
    for (int i = 0; i < 8; i++) mem_b[i] = mem_a[i];

    rst = 1'b1; reqv_a = 1'b0; reqv_b = 1'b0;
    req_we = 1'b0; req_f3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ready", {31'd0, rdy_a}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rv_a}, 32'd0);
    chk("reset_rsp_err", {31'd0, er_a}, 32'd0);
    chk("reset_rsp_rdata", rd_a, 32'd0);
    chk("reset_strobes", {30'd0, memr_a, memw_a}, 32'd0);
    chk("reset_mem_ctrl", {28'd0, ctrl_a}, 32'd0);
    chk("reset_mem_addr", maddr_a, 32'd0);
    chk("reset_mem_wdata", mwd_a, 32'd0);
    chk("reset_ready_b", {31'd0, rdy_b}, 32'd1);

    for (int i = 0; i < 34; i++) begin
      do_req(vecs[i].b, vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wd,
             rdata, err, lat, nr, nw, busy_bad);
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rd);
      chk($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
      chk($sformatf("v%0d_memr_cycles", i), 32'(nr), 32'(vecs[i].exp_nr));
      chk($sformatf("v%0d_memw_cycles", i), 32'(nw), 32'(vecs[i].exp_nw));
      chk($sformatf("v%0d_busy_ready", i), 32'(busy_bad), 32'd0);
      if (i == 0) chk("lw_native_ctrl", {28'd0, log_ctrl[0]}, 32'd2);
      if (i == 5) begin
        chk("split_load_count", 32'(log_addr.size()), 32'd4);
        for (int j = 0; j < 4 && j < log_addr.size(); j++) begin
          chk($sformatf("split_load_addr%0d", j), log_addr[j], 32'(1 + j));
          chk($sformatf("split_load_ctrl%0d", j), {28'd0, log_ctrl[j]}, 32'd3);
        end
      end
      if (i == 6) begin
        chk("split_store_count", 32'(log_addr.size()), 32'd2);
        if (log_addr.size() == 2) begin
          chk("sb0_addr", log_addr[0], 32'd3);
          chk("sb0_ctrl", {28'd0, log_ctrl[0]}, 32'd5);
          chk("sb0_data", {24'd0, log_wd[0][7:0]}, 32'h34);
          chk("sb1_addr", log_addr[1], 32'd4);
          chk("sb1_data", {24'd0, log_wd[1][7:0]}, 32'h12);
        end
      end
    end

    // Reset in the middle of a split store: bytes 1 and 2 land, byte 3 does not.
    req_we = 1'b1; req_f3 = 3'd2; req_addr = 32'd1; req_wdata = 32'h99887766;
    reqv_a = 1'b1;
    @(posedge clk); #1 reqv_a = 1'b0;
    @(negedge clk);
    chk("rst_split_b0_addr", maddr_a, 32'd1);
    @(negedge clk);
    chk("rst_split_b1_addr", maddr_a, 32'd2);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    begin
      int saw_rsp;
      saw_rsp = 0;
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        if (rv_a) saw_rsp++;
        if (k == 0) begin
          chk("abort_ready", {31'd0, rdy_a}, 32'd1);
          chk("abort_strobes", {30'd0, memr_a, memw_a}, 32'd0);
        end
      end
      chk("abort_no_rsp", 32'(saw_rsp), 32'd0);
    end
    do_req(1'b0, 1'b0, 3'd2, 32'd0, 32'd0, rdata, err, lat, nr, nw, busy_bad);
    chk("after_abort_lw0", rdata, 32'h347766dd);
    chk("after_abort_lat", 32'(lat), 32'd2);

    chk("memr_memw_exclusive", 32'(both_hi), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
